// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU and its sequencing front-end
// Contents: default datapath width, ALU opcode encodings, front-end FSM state encoding.
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - command and result handshake bundle of the ALU front-end
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_use_acc (command channel),
//          res_valid/res_ready/res_data/res_zero/res_neg (result channel).
// Modports: master = host side, slave = alu_seq_ctrl side.
interface alu_seq_ctrl_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_neg;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        input  cmd_ready, res_valid, res_data, res_zero, res_neg
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        output cmd_ready, res_valid, res_data, res_zero, res_neg
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU driven by alu_seq_ctrl
// Ports: in1, in2 operands; opcode selects the operation; out is the result (modulo 2^WIDTH).
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] out
);
    always_comb begin
        out = '0;
        case (opcode)
            OP_ADD:  out = in1 + in2;
            OP_SUB:  out = in1 - in2;
            OP_NOT:  out = ~in1;
            OP_AND:  out = in1 & in2;
            OP_OR:   out = in1 | in2;
            OP_XOR:  out = in1 ^ in2;
            OP_SHL:  out = {in1[WIDTH-2:0], 1'b0};
            OP_SHR:  out = {1'b0, in1[WIDTH-1:1]};
            default: out = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequential command front-end for the combinational ALU
// Ports: clk, rst_n (sync active-low); bus (slave) carries the command and result handshakes;
//        acc_clr clears the accumulator; alu_in1/alu_in2/alu_opcode drive the ALU (registered);
//        alu_out is the ALU result; cmd_count counts consumed results (wraps).
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_ctrl_if.slave    bus,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    output logic [CNT_W-1:0] cmd_count
);
    seq_state_t       state;
    logic [WIDTH-1:0] acc;
    logic             cmd_ready_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_zero_q;
    logic             res_neg_q;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_neg   = res_neg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_opcode  <= OP_ADD;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b1;
            res_neg_q   <= 1'b0;
            cmd_count   <= '0;
        end else begin
            // Clear is a default; the EXEC capture below overrides it.
            if (acc_clr) begin
                acc <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        // A simultaneous clear makes the accumulator operand read as 0.
                        if (bus.cmd_use_acc) begin
                            alu_in1 <= acc_clr ? '0 : acc;
                        end else begin
                            alu_in1 <= bus.cmd_a;
                        end
                        alu_in2     <= bus.cmd_b;
                        alu_opcode  <= bus.cmd_op;
                        cmd_ready_q <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    // The ALU has had one full period on the registered operands.
                    res_data_q  <= alu_out;
                    acc         <= alu_out;
                    res_zero_q  <= (alu_out == '0);
                    res_neg_q   <= alu_out[WIDTH-1];
                    res_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end

                ST_RESP: begin
                    if (bus.res_ready) begin
                        cmd_count   <= cmd_count + 1'b1;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    res_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl with the ALU beside it
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          acc_clr;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_in2;
    logic [2:0]    alu_opcode;
    logic [W-1:0]  alu_out;
    logic [15:0]   cmd_count;

    int            n_assert;
    int            n_fail;
    logic [15:0]   exp_count;
    logic [W-1:0]  held;

    alu_seq_ctrl_if #(.WIDTH(W)) bus ();

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .acc_clr    (acc_clr),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .cmd_count  (cmd_count)
    );

    alu #(.WIDTH(W)) u_alu (
        .in1    (alu_in1),
        .in2    (alu_in2),
        .opcode (alu_opcode),
        .out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running required done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command with res_ready=1 and check accept, capture and hand-back.
    // Starts and ends just after a falling edge with the block in IDLE.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic use_acc, input logic clr,
                           input logic [W-1:0] exp_in1, input logic [W-1:0] exp_res);
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = use_acc;
        acc_clr         = clr;
        bus.cmd_valid   = 1'b1;
        bus.res_ready   = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        acc_clr       = 1'b0;
        chk({tag, ".exec_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
        chk({tag, ".exec_valid"}, {31'd0, bus.res_valid}, 32'd0);
        chk({tag, ".in1"}, alu_in1, exp_in1);
        chk({tag, ".in2"}, alu_in2, b);
        chk({tag, ".opcode"}, {29'd0, alu_opcode}, {29'd0, op});
        @(negedge clk);
        chk({tag, ".res_valid"}, {31'd0, bus.res_valid}, 32'd1);
        chk({tag, ".res_data"}, bus.res_data, exp_res);
        chk({tag, ".res_zero"}, {31'd0, bus.res_zero}, {31'd0, exp_res == 0});
        chk({tag, ".res_neg"}, {31'd0, bus.res_neg}, {31'd0, exp_res[W-1]});
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        chk({tag, ".idle_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        chk({tag, ".idle_valid"}, {31'd0, bus.res_valid}, 32'd0);
        chk({tag, ".count"}, {16'd0, cmd_count}, {16'd0, exp_count});
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        exp_count       = 16'd0;
        rst_n           = 1'b0;
        acc_clr         = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = OP_ADD;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_use_acc = 1'b0;
        bus.res_ready   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst.cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst.res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst.res_data", bus.res_data, 32'd0);
        chk("rst.res_zero", {31'd0, bus.res_zero}, 32'd1);
        chk("rst.res_neg", {31'd0, bus.res_neg}, 32'd0);
        chk("rst.count", {16'd0, cmd_count}, 32'd0);
        chk("rst.in1", alu_in1, 32'd0);
        chk("rst.opcode", {29'd0, alu_opcode}, 32'd0);

        // Every opcode with A=2000, B=1000
        run_cmd("add", OP_ADD, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd3000);
        run_cmd("sub", OP_SUB, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd1000);
        run_cmd("not", OP_NOT, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd4294965295);
        run_cmd("and", OP_AND, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd960);
        run_cmd("or",  OP_OR,  32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd2040);
        run_cmd("xor", OP_XOR, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd1080);
        run_cmd("shl", OP_SHL, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd4000);
        run_cmd("shr", OP_SHR, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd1000);

        // Accumulate chain, then clear coinciding with an accumulator command
        run_cmd("chain0", OP_ADD, 32'd2000, 32'd1000, 1'b0, 1'b0, 32'd2000, 32'd3000);
        run_cmd("chain1", OP_ADD, 32'd7, 32'd1000, 1'b1, 1'b0, 32'd3000, 32'd4000);
        run_cmd("chain2", OP_SHL, 32'd7, 32'd1000, 1'b1, 1'b0, 32'd4000, 32'd8000);
        run_cmd("clr_sub", OP_SUB, 32'd7, 32'd1, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF);

        // Zero flag
        run_cmd("zero", OP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0);

        // Backpressure: result held, new command ignored
        bus.cmd_op      = OP_ADD;
        bus.cmd_a       = 32'd11;
        bus.cmd_b       = 32'd22;
        bus.cmd_use_acc = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.res_ready   = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp.valid", {31'd0, bus.res_valid}, 32'd1);
        chk("bp.data", bus.res_data, 32'd33);
        bus.cmd_a     = 32'd500;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold_data", bus.res_data, 32'd33);
            chk("bp.hold_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("bp.hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
            chk("bp.hold_in1", alu_in1, 32'd11);
            chk("bp.hold_count", {16'd0, cmd_count}, {16'd0, exp_count});
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        chk("bp.count", {16'd0, cmd_count}, {16'd0, exp_count});
        chk("bp.released", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
        chk("bp.count_once", {16'd0, cmd_count}, {16'd0, exp_count});
        chk("bp.ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Reset during EXEC aborts the command
        bus.cmd_op    = OP_ADD;
        bus.cmd_a     = 32'd100;
        bus.cmd_b     = 32'd200;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("rx.in_exec", {31'd0, bus.cmd_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rx.res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rx.count", {16'd0, cmd_count}, 32'd0);
        chk("rx.res_zero", {31'd0, bus.res_zero}, 32'd1);
        chk("rx.in1", alu_in1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rx.ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rx.no_result", {31'd0, bus.res_valid}, 32'd0);
        exp_count = 16'd0;
        run_cmd("rx.acc_zero", OP_ADD, 32'd9, 32'd5, 1'b1, 1'b0, 32'd0, 32'd5);

        // Counter wrap
        force dut.cmd_count = 16'hFFFF;
        #1;
        release dut.cmd_count;
        chk("wrap.preset", {16'd0, cmd_count}, 32'h0000_FFFF);
        exp_count = 16'hFFFF;
        run_cmd("wrap", OP_OR, 32'h0F0F_0000, 32'h0000_00F0, 1'b0, 1'b0, 32'h0F0F_0000, 32'h0F0F_00F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
